seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan_pkg.sv | 45 ++++
 rtl/seg_scan_if.sv | 41 ++++
 rtl/seg_glyph.sv | 13 +
 rtl/seg_scan.sv | 169 ++++++++++++++++
 tb/tb_seg_scan.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg -- shared display constants for the multiplexed 7-segment
// scanner.
//
// Contents:
//   SEG_A_BIT / SEG_G_BIT / SEG_DP_BIT  bit positions inside the 8-bit seg bus
//   SEG_OFF                             all segments dark, before polarity
//   GLYPH_ROM                           16 hex glyphs, a..g packed as [6:0]
//   idx_width()                         digit index width, never below 1
package seg_scan_pkg;

    // seg[7] = a ... seg[1] = g, seg[0] = decimal point
    localparam int SEG_A_BIT  = 7;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    // Dark pattern in "1 = lit" terms; polarity is applied later.
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Glyph table, entry n = segments a..g for hex digit n (1 = lit).
    // Each entry is the 8-bit seg pattern without the dp bit.
    localparam logic [15:0][6:0] GLYPH_ROM = {
        7'h47,  // F  (8E)
        7'h4F,  // E  (9E)
        7'h3D,  // d  (7A)
        7'h4E,  // C  (9C)
        7'h1F,  // b  (3E)
        7'h77,  // A  (EE)
        7'h7B,  // 9  (F6)
        7'h7F,  // 8  (FE)
        7'h70,  // 7  (E0)
        7'h5F,  // 6  (BE)
        7'h5B,  // 5  (B6)
        7'h33,  // 4  (66)
        7'h79,  // 3  (F2)
        7'h6D,  // 2  (DA)
        7'h30,  // 1  (60)
        7'h7E   // 0  (FC)
    };

    // Width of a digit index; a single-digit display still gets one bit.
    function automatic int idx_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// seg_scan_if -- bundle between a display producer and the scanner.
//
// Signals:
//   load        producer -> scanner  single-cycle capture strobe
//   data        producer -> scanner  4*NDIG bits of hex nibbles, digit 0 in [3:0]
//   dp          producer -> scanner  decimal point request per digit
//   lz_en       producer -> scanner  leading-zero blanking enable
//   blank       producer -> scanner  live global blank (not latched)
//   seg         scanner  -> producer segment drive a..g,dp
//   an          scanner  -> producer one-hot digit enable
//   busy_digit  scanner  -> producer index of the digit being shown
//
// Handshake: load is a plain strobe with no backpressure. data, dp and
// lz_en are sampled only on a rising edge where load=1 and are ignored on
// every other edge; the scanner always accepts, so there is no ready.
interface seg_scan_if
    import seg_scan_pkg::*;
#(
    parameter int NDIG = 8
);
    localparam int IW = idx_width(NDIG);

    logic                 load;
    logic [4*NDIG-1:0]    data;
    logic [NDIG-1:0]      dp;
    logic                 lz_en;
    logic                 blank;
    logic [7:0]           seg;
    logic [NDIG-1:0]      an;
    logic [IW-1:0]        busy_digit;

    modport master (
        output load, data, dp, lz_en, blank,
        input  seg, an, busy_digit
    );

    modport slave (
        input  load, data, dp, lz_en, blank,
        output seg, an, busy_digit
    );
endinterface

// File: rtl/seg_glyph.sv
// seg_glyph -- combinational hex nibble to 7-segment glyph lookup.
//
// Ports:
//   nib    in   4-bit hex value
//   glyph  out  segments a..g in [6:0], 1 = lit
module seg_glyph
    import seg_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);
    assign glyph = GLYPH_ROM[nib];
endmodule

// File: rtl/seg_scan.sv
// seg_scan -- time-multiplexed 7-segment display scanner.
//
// A prescaler divides clk by SCAN_DIV and steps a digit index through
// 0..NDIG-1. A display register (nibbles, dp, lz_en) is captured on load.
// Every cycle the selected digit is decoded, blanked if needed, put into
// the requested polarity and registered onto seg / an / busy_digit.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   seg_scan_if.slave (load, data, dp, lz_en, blank -> seg, an, busy_digit)
//
// Parameters:
//   NDIG        digits, 1..16
//   SCAN_DIV    clk cycles per digit, 2..2^20
//   ACTIVE_LOW  1: seg/an are active-low, 0: active-high
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int NDIG       = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
)(
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);
    localparam int IW = idx_width(NDIG);
    localparam int PW = $clog2(SCAN_DIV);

    // Idle levels of the output pins, with polarity already applied.
    localparam logic [7:0]      SEG_IDLE = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [NDIG-1:0] AN_IDLE  = (ACTIVE_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

    // ---------------- prescaler and digit index ----------------
    logic [PW-1:0] pre_q;
    logic [IW-1:0] idx_q;
    logic          tick;

    assign tick = (pre_q == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // With NDIG=1 the terminal index is 0, so the index never moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else if (tick) begin
            if (idx_q == IW'(NDIG - 1)) begin
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // ---------------- display register ----------------
    logic [4*NDIG-1:0] nib_q;
    logic [NDIG-1:0]   dp_q;
    logic              lz_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            nib_q <= '0;
            dp_q  <= '0;
            lz_q  <= 1'b0;
        end else if (bus.load) begin
            nib_q <= bus.data;
            dp_q  <= bus.dp;
            lz_q  <= bus.lz_en;
        end
    end

    // ---------------- leading-zero mask ----------------
    // lead_zero[k] is set when nibbles NDIG-1 down to k are all zero.
    // Bit 0 is never set, so a zero value still shows a single "0".
    logic [NDIG-1:0] lead_zero;
    logic            zero_run;

    always_comb begin
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            zero_run     = zero_run & (nib_q[4*k +: 4] == 4'h0);
            lead_zero[k] = zero_run;
        end
    end

    // ---------------- digit select ----------------
    logic [3:0]      sel_nib;
    logic            sel_dp;
    logic            sel_lz;
    logic [NDIG-1:0] an_raw;

    always_comb begin
        sel_nib = 4'h0;
        sel_dp  = 1'b0;
        sel_lz  = 1'b0;
        an_raw  = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx_q == IW'(k)) begin
                sel_nib   = nib_q[4*k +: 4];
                sel_dp    = dp_q[k];
                sel_lz    = lead_zero[k];
                an_raw[k] = 1'b1;
            end
        end
    end

    logic [6:0] glyph;

    seg_glyph u_glyph (
        .nib   (sel_nib),
        .glyph (glyph)
    );

    // ---------------- blanking and polarity ----------------
    // A leading-zero digit goes dark but keeps its an slot so the duty
    // cycle of every digit stays the same; global blank darkens both.
    logic [7:0]      seg_raw;
    logic [NDIG-1:0] an_act;
    logic [7:0]      seg_nxt;
    logic [NDIG-1:0] an_nxt;

    always_comb begin
        seg_raw = SEG_OFF;
        an_act  = an_raw;
        if (!(lz_q && sel_lz)) begin
            seg_raw[SEG_A_BIT:SEG_G_BIT] = glyph;
            seg_raw[SEG_DP_BIT]          = sel_dp;
        end
        if (bus.blank) begin
            seg_raw = SEG_OFF;
            an_act  = '0;
        end
        seg_nxt = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        an_nxt  = (ACTIVE_LOW != 0) ? ~an_act  : an_act;
    end

    // ---------------- output registers ----------------
    logic [7:0]      seg_q;
    logic [NDIG-1:0] an_q;
    logic [IW-1:0]   busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q  <= SEG_IDLE;
            an_q   <= AN_IDLE;
            busy_q <= '0;
        end else begin
            seg_q  <= seg_nxt;
            an_q   <= an_nxt;
            busy_q <= idx_q;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.busy_digit = busy_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan -- bench for seg_scan: two instances (active-low and
// active-high) share one stimulus stream and one reference model.
module tb_seg_scan;
    localparam int NDIG     = 4;
    localparam int SCAN_DIV = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   = 1'b1;
    logic        load  = 1'b0;
    logic [15:0] data  = '0;
    logic [3:0]  dp    = '0;
    logic        lz_en = 1'b0;
    logic        blank = 1'b0;

    seg_scan_if #(.NDIG(NDIG)) if_al ();
    seg_scan_if #(.NDIG(NDIG)) if_ah ();

    assign if_al.load  = load;
    assign if_al.data  = data;
    assign if_al.dp    = dp;
    assign if_al.lz_en = lz_en;
    assign if_al.blank = blank;
    assign if_ah.load  = load;
    assign if_ah.data  = data;
    assign if_ah.dp    = dp;
    assign if_ah.lz_en = lz_en;
    assign if_ah.blank = blank;

    seg_scan #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1)) dut_al (
        .clk (clk),
        .rst (rst),
        .bus (if_al.slave)
    );

    seg_scan #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(0)) dut_ah (
        .clk (clk),
        .rst (rst),
        .bus (if_ah.slave)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Digit shown after an edge depends only on how many non-reset edges
    // came before it: index = floor(n / SCAN_DIV) mod NDIG.
    int          nrun   = 0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp   = '0;
    logic        m_lz   = 1'b0;

    // Expected {seg (1 = lit), an (1 = on), busy} per edge.
    logic [13:0] exp_q[$];

    function automatic logic [7:0] glyph_ref(input logic [3:0] n);
        case (n)
            4'h0: return 8'hFC;  4'h1: return 8'h60;
            4'h2: return 8'hDA;  4'h3: return 8'hF2;
            4'h4: return 8'h66;  4'h5: return 8'hB6;
            4'h6: return 8'hBE;  4'h7: return 8'hE0;
            4'h8: return 8'hFE;  4'h9: return 8'hF6;
            4'hA: return 8'hEE;  4'hB: return 8'h3E;
            4'hC: return 8'h9C;  4'hD: return 8'h7A;
            4'hE: return 8'h9E;  default: return 8'h8E;
        endcase
    endfunction

    task automatic model_edge();
        logic [7:0]  s;
        logic [3:0]  a;
        logic [15:0] upper;
        int          idx;
        s   = 8'h00;
        a   = 4'h0;
        idx = 0;
        if (rst) begin
            nrun   = 0;
            m_data = '0;
            m_dp   = '0;
            m_lz   = 1'b0;
        end else begin
            idx   = (nrun / SCAN_DIV) % NDIG;
            upper = m_data >> (4 * idx);
            if (!blank) begin
                a = 4'(1 << idx);
                if (m_lz && idx != 0 && upper == 16'h0)
                    s = 8'h00;
                else
                    s = glyph_ref(upper[3:0]) | {7'b0, m_dp[idx]};
            end
            if (load) begin
                m_data = data;
                m_dp   = dp;
                m_lz   = lz_en;
            end
            nrun++;
        end
        exp_q.push_back({s, a, 2'(idx)});
    endtask

    task automatic compare();
        logic [13:0] e;
        logic [7:0]  s_inv;
        logic [3:0]  a_inv;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd1, 32'd0);
        end else begin
            e     = exp_q.pop_front();
            s_inv = ~e[13:6];
            a_inv = ~e[5:2];
            check("seg_al",  if_al.seg,        s_inv);
            check("an_al",   if_al.an,         a_inv);
            check("busy_al", if_al.busy_digit, e[1:0]);
            check("seg_ah",  if_ah.seg,        e[13:6]);
            check("an_ah",   if_ah.an,         e[5:2]);
            check("busy_ah", if_ah.busy_digit, e[1:0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic lz);
        load  = 1'b1;
        data  = d;
        dp    = p;
        lz_en = lz;
        step();
        load  = 1'b0;
        data  = 16'($urandom);
        dp    = 4'($urandom);
        lz_en = 1'($urandom);
    endtask

    // Advance until the next edge is a prescaler terminal count.
    task automatic wait_tick_edge();
        int budget;
        budget = 4 * SCAN_DIV;
        while ((nrun % SCAN_DIV) != SCAN_DIV - 1 && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check("tick_timeout", 32'd1, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // reset held 3 cycles
        rst = 1'b1;
        run(3);
        check("rst_seg_al", if_al.seg, 32'hFF);
        check("rst_an_al",  if_al.an,  32'hF);
        check("rst_seg_ah", if_ah.seg, 32'h00);
        check("rst_an_ah",  if_ah.an,  32'h0);

        // first cycle after release: digit 0 showing "0"
        rst = 1'b0;
        step();
        check("rel_an_al",  if_al.an,  32'hE);
        check("rel_seg_al", if_al.seg, 32'h03);

        // free scan
        run(32);

        // leading-zero blanking
        do_load(16'h0042, 4'b0000, 1'b1);
        run(16);
        do_load(16'h0000, 4'b0000, 1'b1);
        run(16);

        // hex glyphs and decimal point
        do_load(16'hABCD, 4'b0100, 1'b0);
        run(16);

        // load coinciding with a tick
        wait_tick_edge();
        do_load(16'h5E31, 4'b1010, 1'b0);
        run(8);

        // global blank for 5 cycles, then resume
        blank = 1'b1;
        run(5);
        blank = 1'b0;
        run(16);

        // reset together with load: load is dropped
        rst = 1'b1;
        load = 1'b1;
        data = 16'h1234;
        step();
        load = 1'b0;
        rst  = 1'b0;
        run(16);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 149) == 0);
            load  = ($urandom_range(0, 7) == 0);
            data  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp    = 4'($urandom);
            lz_en = 1'($urandom_range(0, 1));
            blank = ($urandom_range(0, 9) == 0);
            step();
        end
        rst   = 1'b0;
        load  = 1'b0;
        blank = 1'b0;
        run(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
